// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one completed FU result per cycle (ROB-head first,
// then round-robin) and broadcasts the winner's payload on the following cycle.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 64,
  parameter int PHYS_W    = 6,
  parameter int DATA_W    = 32,
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH),
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   i_req_rob_idx,
  input  logic [NUM_REQ*PHYS_W-1:0]      i_req_pd,
  input  logic [NUM_REQ*DATA_W-1:0]      i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [ROB_IDX_W-1:0]           i_rob_commit_idx,
  input  logic                           i_flush,
  output logic                           o_cdb_valid,
  output logic [ROB_IDX_W-1:0]           o_cdb_rob_idx,
  output logic [PHYS_W-1:0]              o_cdb_pd,
  output logic [DATA_W-1:0]              o_cdb_data,
  output logic [SRC_W-1:0]               o_cdb_src,
  output logic [SRC_W-1:0]               o_dbg_rr_ptr
);

  // Handshake: producer i holds i_req_valid and payload stable until o_req_ready[i]=1;
  // a transfer happens in the cycle where both are high, and o_req_ready is one-hot or zero.
  logic [SRC_W-1:0]     r_rr_ptr;
  logic                 r_cdb_valid;
  logic [ROB_IDX_W-1:0] r_cdb_rob_idx;
  logic [PHYS_W-1:0]    r_cdb_pd;
  logic [DATA_W-1:0]    r_cdb_data;
  logic [SRC_W-1:0]     r_cdb_src;

  logic [NUM_REQ-1:0]   w_elig;
  logic                 w_head_hit;
  logic [SRC_W-1:0]     w_head_idx;
  logic                 w_rr_hit;
  logic [SRC_W-1:0]     w_rr_idx;
  logic                 w_grant_any;
  logic [SRC_W-1:0]     w_grant_idx;
  logic [SRC_W-1:0]     w_next_ptr;
  logic [ROB_IDX_W-1:0] w_sel_rob_idx;
  logic [PHYS_W-1:0]    w_sel_pd;
  logic [DATA_W-1:0]    w_sel_data;

  always_comb begin
    w_elig     = i_req_valid & ~{NUM_REQ{i_flush}};
    w_head_hit = 1'b0;
    w_head_idx = '0;
    w_rr_hit   = 1'b0;
    w_rr_idx   = '0;
    // Descending scans so the last assignment is the lowest index / nearest to rr_ptr.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i] && (i_req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] == i_rob_commit_idx)) begin
        w_head_hit = 1'b1;
        w_head_idx = SRC_W'(i);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (w_elig[j]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = SRC_W'(j);
      end
    end
    w_grant_any = w_head_hit | w_rr_hit;
    w_grant_idx = w_head_hit ? w_head_idx : w_rr_idx;
    w_next_ptr  = (int'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + 1'b1;
  end

  always_comb begin
    w_sel_rob_idx = '0;
    w_sel_pd      = '0;
    w_sel_data    = '0;
    o_req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(w_grant_idx) == i) begin
        w_sel_rob_idx  = i_req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
        w_sel_pd       = i_req_pd[i*PHYS_W +: PHYS_W];
        w_sel_data     = i_req_data[i*DATA_W +: DATA_W];
        o_req_ready[i] = w_grant_any & ~i_rst;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr      <= '0;
      r_cdb_valid   <= 1'b0;
      r_cdb_rob_idx <= '0;
      r_cdb_pd      <= '0;
      r_cdb_data    <= '0;
      r_cdb_src     <= '0;
    end else begin
      r_cdb_valid <= w_grant_any;
      if (w_grant_any) begin
        r_rr_ptr      <= w_next_ptr;
        r_cdb_rob_idx <= w_sel_rob_idx;
        r_cdb_pd      <= w_sel_pd;
        r_cdb_data    <= w_sel_data;
        r_cdb_src     <= w_grant_idx;
      end
    end
  end

  assign o_cdb_valid   = r_cdb_valid;
  assign o_cdb_rob_idx = r_cdb_rob_idx;
  assign o_cdb_pd      = r_cdb_pd;
  assign o_cdb_data    = r_cdb_data;
  assign o_cdb_src     = r_cdb_src;
  assign o_dbg_rr_ptr  = r_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized producers, all checked
// against a rule-level model of grant selection and broadcast.
module tb_cdb_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [5:0]   rob_idx [N];
  logic [5:0]   pd [N];
  logic [31:0]  data [N];
  logic [N*6-1:0]  req_rob_idx_flat;
  logic [N*6-1:0]  req_pd_flat;
  logic [N*32-1:0] req_data_flat;
  logic [N-1:0] req_ready;
  logic [5:0]   rob_commit_idx;
  logic         flush;
  logic         cdb_valid;
  logic [5:0]   cdb_rob_idx;
  logic [5:0]   cdb_pd;
  logic [31:0]  cdb_data;
  logic [1:0]   cdb_src;
  logic [1:0]   dbg_rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pointer, last broadcast, and queue of expected broadcasts.
  int          m_ptr = 0;
  logic [45:0] m_last = '0;
  logic [45:0] exp_q[$];
  int          waits [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_rob_idx_flat[i*6 +: 6] = rob_idx[i];
      req_pd_flat[i*6 +: 6]      = pd[i];
      req_data_flat[i*32 +: 32]  = data[i];
    end
  end

  cdb_arbiter #(.NUM_REQ(4), .ROB_DEPTH(64), .PHYS_W(6), .DATA_W(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_valid      (req_valid),
    .i_req_rob_idx    (req_rob_idx_flat),
    .i_req_pd         (req_pd_flat),
    .i_req_data       (req_data_flat),
    .o_req_ready      (req_ready),
    .i_rob_commit_idx (rob_commit_idx),
    .i_flush          (flush),
    .o_cdb_valid      (cdb_valid),
    .o_cdb_rob_idx    (cdb_rob_idx),
    .o_cdb_pd         (cdb_pd),
    .o_cdb_data       (cdb_data),
    .o_cdb_src        (cdb_src),
    .o_dbg_rr_ptr     (dbg_rr_ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Head match wins (lowest index), otherwise first valid visiting ptr, ptr+1, ... mod N.
  function automatic int model_grant();
    int order[$];
    if (flush) return -1;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && rob_idx[i] == rob_commit_idx) return i;
    for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
    foreach (order[k])
      if (req_valid[order[k]]) return order[k];
    return -1;
  endfunction

  function automatic logic [45:0] pack_entry(input int g);
    logic [1:0] s;
    s = g[1:0];
    return {rob_idx[g], pd[g], data[g], s};
  endfunction

  // One cycle: check grant before the edge, check broadcast and pointer after it.
  task automatic step(output int g);
    logic [45:0] e;
    logic        exp_valid;
    @(negedge clk);
    g = model_grant();
    check("req_ready", {60'd0, req_ready}, (g >= 0) ? (64'd1 << g) : 64'd0);
    check("onehot", {63'd0, $countones(req_ready) <= 1}, 64'd1);
    exp_valid = (g >= 0);
    if (exp_valid) begin
      exp_q.push_back(pack_entry(g));
      m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
    check("cdb_valid", {63'd0, cdb_valid}, {63'd0, exp_valid});
    if (exp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_last = e;
    end
    check(exp_valid ? "cdb_payload" : "cdb_hold",
          {18'd0, cdb_rob_idx, cdb_pd, cdb_data, cdb_src}, {18'd0, m_last});
    check("rr_ptr", {62'd0, dbg_rr_ptr}, m_ptr);
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    flush = 1'b0;
    rob_commit_idx = 6'd0;
    for (int i = 0; i < N; i++) begin
      rob_idx[i] = 6'd0;
      pd[i] = 6'd0;
      data[i] = 32'd0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_last = '0;
    exp_q.delete();
  endtask

  task automatic fuzz(input int cycles, input bit head_mode);
    int g;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          rob_idx[i] = head_mode ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 31));
          pd[i] = 6'($urandom_range(0, 63));
          data[i] = $urandom;
        end
      end
      rob_commit_idx = head_mode ? 6'($urandom_range(0, 7)) : 6'($urandom_range(32, 63));
      flush = ($urandom_range(0, 15) == 0);
      step(g);
      if (flush) begin
        req_valid = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (i == g) begin
            if (!head_mode) check("rr_bound", {63'd0, waits[i] < N}, 64'd1);
            waits[i] = 0;
            req_valid[i] = 1'b0;
          end else if (req_valid[i]) begin
            waits[i]++;
          end
        end
      end
    end
    flush = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    int g;
    int pulses;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {63'd0, cdb_valid}, 64'd0);
    check("reset_ptr", {62'd0, dbg_rr_ptr}, 64'd0);
    check("reset_payload", {18'd0, cdb_rob_idx, cdb_pd, cdb_data, cdb_src}, 64'd0);
    rst = 1'b0;

    // Round-robin: all four held with no head match.
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) rob_idx[i] = 6'(10 + i);
    rob_commit_idx = 6'd40;
    for (int c = 0; c < 8; c++) begin
      step(g);
      check("rr_seq", g, c % N);
      check("rr_src", {62'd0, cdb_src}, c % N);
    end

    // Reset mid-burst: visible at once, without a clock edge.
    step(g);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {63'd0, cdb_valid}, 64'd0);
    check("async_rst_ready", {60'd0, req_ready}, 64'd0);
    check("async_rst_ptr", {62'd0, dbg_rr_ptr}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(g);
    check("post_rst_grant", g, 0);
    check("post_rst_src", {62'd0, cdb_src}, 64'd0);

    // Bring pointer back to 0 via a lone req3, then head priority.
    req_valid = 4'b1000;
    step(g);
    req_valid = 4'b0101;
    rob_idx[0] = 6'd5;
    rob_idx[2] = 6'd9;
    rob_commit_idx = 6'd9;
    step(g);
    check("head_rob", {58'd0, cdb_rob_idx}, 64'd9);
    check("head_src", {62'd0, cdb_src}, 64'd2);
    check("head_ptr", {62'd0, dbg_rr_ptr}, 64'd3);

    // Lone payload at the top ROB index.
    req_valid = 4'b0010;
    rob_idx[1] = 6'd63;
    pd[1] = 6'd17;
    data[1] = 32'hDEADBEEF;
    rob_commit_idx = 6'd0;
    step(g);
    check("pl_valid", {63'd0, cdb_valid}, 64'd1);
    check("pl_pd", {58'd0, cdb_pd}, 64'd17);
    check("pl_data", {32'd0, cdb_data}, 64'hDEADBEEF);
    check("pl_rob", {58'd0, cdb_rob_idx}, 64'd63);

    // Flush right after a req3 grant.
    req_valid = 4'b1000;
    step(g);
    check("fl_t1_valid", {63'd0, cdb_valid}, 64'd1);
    check("fl_t1_src", {62'd0, cdb_src}, 64'd3);
    req_valid = 4'b0011;
    flush = 1'b1;
    step(g);
    check("fl_grant", g, -1);
    check("fl_t2_valid", {63'd0, cdb_valid}, 64'd0);
    check("fl_ptr", {62'd0, dbg_rr_ptr}, 64'd0);
    flush = 1'b0;
    req_valid = '0;

    // Single pulse then idle: one broadcast, data held.
    req_valid = 4'b0100;
    data[2] = 32'hA5A5_1234;
    rob_idx[2] = 6'd20;
    pulses = 0;
    step(g);
    pulses += cdb_valid;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step(g);
      pulses += cdb_valid;
    end
    check("pulse_count", pulses, 1);
    check("idle_hold_data", {32'd0, cdb_data}, 64'hA5A5_1234);

    fuzz(300, 1'b0);
    fuzz(200, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
